// File: rtl/cs_resolve_pipe.sv
// cs_resolve_pipe: segmented carry-propagate adder that turns a registered
// carry-save triple into one binary word, SEG_W bits resolved per stage.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   s_in, c_in, cout_in  carry-save word: s weight 2^i, c weight 2^(i+1),
//                        cout weight 2^IN_W
//   out_valid/out_ready  downstream handshake
//   result               binary sum truncated to OUT_W bits
//   ovf_out              only with CS_RESOLVE_OVF_EN: dropped upper bits nonzero
//
// Build option: define CS_RESOLVE_OVF_EN to add the ovf_out port.

module cs_resolve_pipe #(
   parameter int IN_W  = 16,
   parameter int SEG_W = 4,
   parameter int OUT_W = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  s_in,
   input  logic [IN_W-1:0]  c_in,
   input  logic             cout_in,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef CS_RESOLVE_OVF_EN
   output logic [OUT_W-1:0] result,
   output logic             ovf_out
`else
   output logic [OUT_W-1:0] result
`endif
);

   localparam int A_W     = IN_W + 2;
   localparam int NUM_SEG = (A_W + SEG_W - 1) / SEG_W;

   logic               adv;
   logic [NUM_SEG-1:0] vld;
   logic [A_W-1:0]     op_a;
   logic [A_W-1:0]     op_b;

   // Whole pipe moves as one; a stall freezes every stage.
   assign out_valid = vld[NUM_SEG-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   assign op_a = {1'b0, cout_in, s_in};
   assign op_b = {1'b0, c_in, 1'b0};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (adv) begin
         vld <= (vld << 1) | NUM_SEG'(in_valid);
      end
   end

   // Stage k resolves bits [LO +: W]. Operand bits above the segment
   // ride forward in g_fwd; resolved bits grow in res_q.
   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
      localparam int LO  = k * SEG_W;
      localparam int REM = A_W - LO;
      localparam int W   = (REM < SEG_W) ? REM : SEG_W;
      localparam int NXT = REM - W;

      logic [REM-1:0]  a_cur;
      logic [REM-1:0]  b_cur;
      logic            cin;
      logic [W:0]      sum;
      logic [LO+W-1:0] res_d;
      logic [LO+W-1:0] res_q;

      if (k == 0) begin : g_src
         assign a_cur = op_a;
         assign b_cur = op_b;
         assign cin   = 1'b0;
         assign res_d = sum[W-1:0];
      end else begin : g_src
         assign a_cur = g_stg[k-1].g_fwd.a_q;
         assign b_cur = g_stg[k-1].g_fwd.b_q;
         assign cin   = g_stg[k-1].g_fwd.co_q;
         assign res_d = {sum[W-1:0], g_stg[k-1].res_q};
      end

      assign sum = {1'b0, a_cur[W-1:0]}
                 + {1'b0, b_cur[W-1:0]}
                 + {{W{1'b0}}, cin};

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            res_q <= '0;
         end else if (adv) begin
            res_q <= res_d;
         end
      end

      // The top stage's carry-out is always zero: the sum fits A_W bits.
      if (NXT > 0) begin : g_fwd
         logic [NXT-1:0] a_q;
         logic [NXT-1:0] b_q;
         logic           co_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q  <= '0;
               b_q  <= '0;
               co_q <= 1'b0;
            end else if (adv) begin
               a_q  <= a_cur[REM-1:W];
               b_q  <= b_cur[REM-1:W];
               co_q <= sum[W];
            end
         end
      end
   end

   assign result = g_stg[NUM_SEG-1].res_q[OUT_W-1:0];

`ifdef CS_RESOLVE_OVF_EN
   logic ovf_d;

   // Flag computed from the same combinational word that loads result,
   // so the two registers stay in step.
   if (OUT_W < A_W) begin : g_ovf
      assign ovf_d = |g_stg[NUM_SEG-1].res_d[A_W-1:OUT_W];
   end else begin : g_ovf
      assign ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_out <= 1'b0;
      end else if (adv) begin
         ovf_out <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_cs_resolve_pipe.sv
// tb_cs_resolve_pipe: directed bench for cs_resolve_pipe
// (IN_W=16, SEG_W=4, OUT_W=18; OUT_W=16 twin with CS_RESOLVE_OVF_EN).

module tb_cs_resolve_pipe;

   typedef struct {
      logic [15:0] s;
      logic [15:0] c;
      logic        co;
      logic [17:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        cout_in = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] s_in = '0;
   logic [15:0] c_in = '0;
   logic        in_ready;
   logic        out_valid;
   logic [17:0] result;
`ifdef CS_RESOLVE_OVF_EN
   logic        ovf18;
   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] result16;
   logic        ovf16;
`endif

   int          errors = 0;
   int          checks = 0;
   int          rx = 0;
   logic [17:0] exp_in = '0;
   logic [17:0] mon_e;
   logic [17:0] q[$];

   always #5 clk = ~clk;

   cs_resolve_pipe #(.IN_W(16), .SEG_W(4), .OUT_W(18)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .s_in(s_in), .c_in(c_in), .cout_in(cout_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
`ifdef CS_RESOLVE_OVF_EN
      , .ovf_out(ovf18)
`endif
   );

`ifdef CS_RESOLVE_OVF_EN
   cs_resolve_pipe #(.IN_W(16), .SEG_W(4), .OUT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready16),
      .s_in(s_in), .c_in(c_in), .cout_in(cout_in),
      .out_valid(out_valid16), .out_ready(out_ready),
      .result(result16), .ovf_out(ovf16)
   );
`endif

   function automatic logic [17:0] ref_sum(input logic [15:0] s,
                                           input logic [15:0] c,
                                           input logic co);
      return {2'b00, s} + {1'b0, c, 1'b0} + {1'b0, co, 16'h0000};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic send(input logic [15:0] s, input logic [15:0] c,
                       input logic co, input logic [17:0] e);
      s_in     = s;
      c_in     = c;
      cout_in  = co;
      exp_in   = e;
      in_valid = 1'b1;
      tick();
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && q.size() != 0; i++) tick();
      chk("drain_empty", q.size(), 0);
   endtask

   // Scoreboard: handshakes are observed mid-cycle, ahead of the edge
   // that completes them.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: got %h expected no word", result);
            end else begin
               mon_e = q.pop_front();
               chk("stream_result", result, mon_e);
               rx++;
`ifdef CS_RESOLVE_OVF_EN
               chk("ovf18", ovf18, 0);
               chk("valid16", out_valid16, 1);
               chk("result16", result16, mon_e[15:0]);
               chk("ovf16", ovf16, |mon_e[17:16]);
`endif
            end
         end
         if (in_valid && in_ready) q.push_back(exp_in);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[12];
      logic [15:0] rs;
      logic [15:0] rc;
      logic        rco;
      logic [17:0] hold;
      int          base;

      tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 18'h00000};
      tbl[1]  = '{16'hFFFF, 16'hFFFF, 1'b1, 18'h3FFFD};
      tbl[2]  = '{16'h0001, 16'h0001, 1'b0, 18'h00003};
      tbl[3]  = '{16'hFFFF, 16'h0000, 1'b0, 18'h0FFFF};
      tbl[4]  = '{16'h0000, 16'h8000, 1'b0, 18'h10000};
      tbl[5]  = '{16'h0000, 16'h0000, 1'b1, 18'h10000};
      tbl[6]  = '{16'h000F, 16'h0008, 1'b0, 18'h0001F};
      tbl[7]  = '{16'h00FF, 16'h0001, 1'b0, 18'h00101};
      tbl[8]  = '{16'h1234, 16'h0F0F, 1'b0, 18'h03052};
      tbl[9]  = '{16'h8000, 16'h8000, 1'b1, 18'h28000};
      tbl[10] = '{16'hAAAA, 16'h5555, 1'b0, 18'h15554};
      tbl[11] = '{16'hFFFF, 16'h0000, 1'b1, 18'h1FFFF};

      // Reset held 3 cycles with a word offered.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      s_in     = 16'hFFFF;
      c_in     = 16'hFFFF;
      cout_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valid", out_valid, 0);
         chk("rst_result", result, 0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) idle();
      chk("rst_no_word", out_valid, 0);

      // Table vectors, one at a time, checked at fixed latency.
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].s, tbl[i].c, tbl[i].co, tbl[i].exp);
         for (int j = 0; j < 3; j++) idle();
         chk("tbl_early", out_valid, 0);
         idle();
         chk("tbl_valid", out_valid, 1);
         chk("tbl_result", result, tbl[i].exp);
      end
      drain();

      // Single word: one-cycle out_valid pulse, 4 edges after accept.
      send(16'hFFFF, 16'hFFFF, 1'b1, 18'h3FFFD);
      for (int i = 1; i <= 5; i++) begin
         idle();
         chk("lat_valid", out_valid, (i == 4) ? 1 : 0);
         if (i == 4) chk("lat_result", result, 18'h3FFFD);
      end

      // Back-to-back random stream.
      base = rx;
      for (int i = 0; i < 100; i++) begin
         rs  = 16'($urandom);
         rc  = 16'($urandom);
         rco = 1'($urandom);
         chk("b2b_in_ready", in_ready, 1);
         send(rs, rc, rco, ref_sum(rs, rc, rco));
      end
      drain();
      chk("b2b_count", rx - base, 100);

      // Stall with 3 words in flight.
      base = rx;
      send(16'h0123, 16'h4567, 1'b0, ref_sum(16'h0123, 16'h4567, 1'b0));
      send(16'hFEDC, 16'hBA98, 1'b1, ref_sum(16'hFEDC, 16'hBA98, 1'b1));
      send(16'h7FFF, 16'h0001, 1'b0, 18'h08001);
      idle();
      out_ready = 1'b0;
      idle();
      chk("stall_valid", out_valid, 1);
      hold = result;
      for (int i = 0; i < 7; i++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_result", result, hold);
         chk("stall_valid_hold", out_valid, 1);
         idle();
      end
      out_ready = 1'b1;
      drain();
      chk("stall_count", rx - base, 3);

      // Reset with 4 words queued.
      for (int i = 0; i < 4; i++) begin
         send(16'h1111, 16'h2222, 1'b0, 18'h05555);
      end
      rst_n    = 1'b0;
      in_valid = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_result", result, 0);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) idle();
      chk("mid_rst_stale", out_valid, 0);
      base = rx;
      send(16'h00FF, 16'h0080, 1'b1, 18'h101FF);
      drain();
      chk("mid_rst_count", rx - base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
